// File: rtl/spm_neuron_net.sv
// spm_neuron_net: three ReLU hidden neurons feeding one linear output neuron, binary32,
// fully pipelined with a fixed 24-cycle input-to-output latency.
module spm_neuron_net (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] i_a1_1,
  input  logic [31:0] i_a1_2,
  input  logic [31:0] i_a1_3,
  input  logic [31:0] i_w1_1,
  input  logic [31:0] i_w1_2,
  input  logic [31:0] i_w1_3,
  input  logic [31:0] i_b1_1,
  input  logic [31:0] i_b1_2,
  input  logic [31:0] i_b1_3,
  input  logic [31:0] i_w2_1,
  input  logic [31:0] i_w2_2,
  input  logic [31:0] i_w2_3,
  output logic [31:0] o_final_result
);

  // Latency budget after the input register: MUL + ADD + 1 (ReLU) + MUL + ADD + ADD + 1 (out) = 24
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned ADD_LAT = 4;
  localparam int unsigned W2_LAT  = MUL_LAT + ADD_LAT + 1;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Round-to-nearest-even on a normalised fraction; overflow to Inf, underflow flushed to signed zero
  function automatic logic [31:0] fp_round(input logic s, input int e, input logic [22:0] f,
                                           input logic g, input logic st);
    logic [23:0] fr;
    int          er;
    fr = {1'b0, f} + {23'd0, g & (st | f[0])};
    er = fr[23] ? e + 1 : e;
    if (er >= 255) return {s, 8'hFF, 23'd0};
    if (er <= 0)   return {s, 31'd0};
    return {s, 8'(er), fr[22:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == '0);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) || is_inf(b))
      return ((a[30:23] == 8'h00) || (b[30:23] == 8'h00)) ? QNAN : {s, 8'hFF, 23'd0};
    if ((a[30:23] == 8'h00) || (b[30:23] == 8'h00)) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return fp_round(s, e + 1, p[46:24], p[23], |p[22:0]);
    return fp_round(s, e, p[45:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, lost;
    logic [27:0] r;
    logic        a_zero, b_zero;
    int          d, e;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (is_nan(a) || is_nan(b)) return QNAN;
    if (is_inf(a) && is_inf(b)) return (a[31] != b[31]) ? QNAN : a;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if (a_zero && b_zero) return 32'd0;
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    e  = int'(x[30:23]);
    d  = e - int'(y[30:23]);
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // Align the smaller operand, folding shifted-out bits into the sticky position
    if (d >= 27) begin
      my = 27'd1;
    end else if (d > 0) begin
      lost = my << (27 - d);
      my   = (my >> d) | {26'd0, |lost};
    end
    if (x[31] == y[31]) begin
      r = {1'b0, mx} + {1'b0, my};
      if (r[27]) begin
        r = {1'b0, r[27:1]} | {27'd0, r[0]};
        e = e + 1;
      end
    end else begin
      r = {1'b0, mx} - {1'b0, my};
      if (r == '0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!r[26]) begin
          r = r << 1;
          e = e - 1;
        end
      end
    end
    return fp_round(x[31], e, r[25:3], r[2], |r[1:0]);
  endfunction

  // Negative non-NaN values (including -0) become +0
  function automatic logic [31:0] relu(input logic [31:0] x);
    return (x[31] && !is_nan(x)) ? 32'd0 : x;
  endfunction

  logic [31:0] w_a  [3];
  logic [31:0] w_w1 [3];
  logic [31:0] w_b  [3];
  logic [31:0] w_w2 [3];

  assign w_a[0]  = i_a1_1;
  assign w_a[1]  = i_a1_2;
  assign w_a[2]  = i_a1_3;
  assign w_w1[0] = i_w1_1;
  assign w_w1[1] = i_w1_2;
  assign w_w1[2] = i_w1_3;
  assign w_b[0]  = i_b1_1;
  assign w_b[1]  = i_b1_2;
  assign w_b[2]  = i_b1_3;
  assign w_w2[0] = i_w2_1;
  assign w_w2[1] = i_w2_2;
  assign w_w2[2] = i_w2_3;

  logic [31:0] r_a   [3];
  logic [31:0] r_w1  [3];
  logic [31:0] r_b   [3];
  logic [31:0] r_w2  [3];
  logic [31:0] r_bd  [3][MUL_LAT];
  logic [31:0] r_m1  [3][MUL_LAT];
  logic [31:0] r_s1  [3][ADD_LAT];
  logic [31:0] r_h   [3];
  logic [31:0] r_w2d [3][W2_LAT];
  logic [31:0] r_m2  [3][MUL_LAT];
  logic [31:0] r_s12 [ADD_LAT];
  logic [31:0] r_m3d [ADD_LAT];
  logic [31:0] r_y   [ADD_LAT];

  // Each FP op is evaluated once and carried through a balancing register chain;
  // bias and output weights ride alongside so every branch stays aligned to one input set.
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int k = 0; k < 3; k++) begin
        r_a[k]  <= '0;
        r_w1[k] <= '0;
        r_b[k]  <= '0;
        r_w2[k] <= '0;
        r_h[k]  <= '0;
        for (int i = 0; i < MUL_LAT; i++) begin
          r_bd[k][i] <= '0;
          r_m1[k][i] <= '0;
          r_m2[k][i] <= '0;
        end
        for (int i = 0; i < ADD_LAT; i++) r_s1[k][i] <= '0;
        for (int i = 0; i < W2_LAT; i++)  r_w2d[k][i] <= '0;
      end
      for (int i = 0; i < ADD_LAT; i++) begin
        r_s12[i] <= '0;
        r_m3d[i] <= '0;
        r_y[i]   <= '0;
      end
      o_final_result <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        r_a[k]      <= w_a[k];
        r_w1[k]     <= w_w1[k];
        r_b[k]      <= w_b[k];
        r_w2[k]     <= w_w2[k];
        r_m1[k][0]  <= fp_mul(r_a[k], r_w1[k]);
        r_bd[k][0]  <= r_b[k];
        r_w2d[k][0] <= r_w2[k];
        r_s1[k][0]  <= fp_add(r_m1[k][MUL_LAT-1], r_bd[k][MUL_LAT-1]);
        r_h[k]      <= relu(r_s1[k][ADD_LAT-1]);
        r_m2[k][0]  <= fp_mul(r_h[k], r_w2d[k][W2_LAT-1]);
        for (int i = 1; i < MUL_LAT; i++) begin
          r_m1[k][i] <= r_m1[k][i-1];
          r_bd[k][i] <= r_bd[k][i-1];
          r_m2[k][i] <= r_m2[k][i-1];
        end
        for (int i = 1; i < ADD_LAT; i++) r_s1[k][i] <= r_s1[k][i-1];
        for (int i = 1; i < W2_LAT; i++)  r_w2d[k][i] <= r_w2d[k][i-1];
      end
      r_s12[0] <= fp_add(r_m2[0][MUL_LAT-1], r_m2[1][MUL_LAT-1]);
      r_m3d[0] <= r_m2[2][MUL_LAT-1];
      r_y[0]   <= fp_add(r_s12[ADD_LAT-1], r_m3d[ADD_LAT-1]);
      for (int i = 1; i < ADD_LAT; i++) begin
        r_s12[i] <= r_s12[i-1];
        r_m3d[i] <= r_m3d[i-1];
        r_y[i]   <= r_y[i-1];
      end
      o_final_result <= r_y[ADD_LAT-1];
    end
  end

endmodule

// File: tb/tb_spm_neuron_net.sv
// Self-checking bench for spm_neuron_net: directed plan vectors plus random exact-valued sets
// scored against a real-arithmetic model through a per-cycle expected-output schedule.
module tb_spm_neuron_net;

  localparam int LAT  = 24;
  localparam int MAXC = 4096;

  typedef logic [11:0][31:0] set_t;  // [0..2]=a, [3..5]=w1, [6..8]=b, [9..11]=w2

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] i_a1_1 = '0, i_a1_2 = '0, i_a1_3 = '0;
  logic [31:0] i_w1_1 = '0, i_w1_2 = '0, i_w1_3 = '0;
  logic [31:0] i_b1_1 = '0, i_b1_2 = '0, i_b1_3 = '0;
  logic [31:0] i_w2_1 = '0, i_w2_2 = '0, i_w2_3 = '0;
  logic [31:0] o_final_result;

  spm_neuron_net dut (
    .clk(clk), .areset(areset),
    .i_a1_1(i_a1_1), .i_a1_2(i_a1_2), .i_a1_3(i_a1_3),
    .i_w1_1(i_w1_1), .i_w1_2(i_w1_2), .i_w1_3(i_w1_3),
    .i_b1_1(i_b1_1), .i_b1_2(i_b1_2), .i_b1_3(i_b1_3),
    .i_w2_1(i_w2_1), .i_w2_2(i_w2_2), .i_w2_3(i_w2_3),
    .o_final_result(o_final_result)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  string       phase = "reset";
  logic [31:0] exp_out [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %08h expected %08h", tag, cyc, got, exp);
    end
  endtask

  function automatic set_t mkset(input logic [31:0] a1, a2, a3, w11, w12, w13,
                                 b1, b2, b3, w21, w22, w23);
    set_t s;
    s[0] = a1;  s[1] = a2;  s[2] = a3;
    s[3] = w11; s[4] = w12; s[5] = w13;
    s[6] = b1;  s[7] = b2;  s[8] = b3;
    s[9] = w21; s[10] = w22; s[11] = w23;
    return s;
  endfunction

  // Exact real -> binary32 for values representable without rounding
  function automatic logic [31:0] r2f(input real x);
    real    m;
    int     e;
    logic   s;
    longint f;
    if (x == 0.0) return 32'd0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = longint'((m - 1.0) * 8388608.0);
    return {s, 8'(e), 23'(f)};
  endfunction

  // Network evaluated directly from its definition
  function automatic logic [31:0] model(input real a[3], input real w1[3], input real b[3],
                                        input real w2[3]);
    real y, h;
    y = 0.0;
    for (int k = 0; k < 3; k++) begin
      h = a[k] * w1[k] + b[k];
      if (h < 0.0) h = 0.0;
      y = y + h * w2[k];
    end
    return r2f(y);
  endfunction

  // One clock: drive a set, record what that edge schedules, then check this edge's output
  task automatic step(input logic rst, input set_t s, input logic [31:0] y);
    areset = rst;
    i_a1_1 = s[0]; i_a1_2 = s[1];  i_a1_3 = s[2];
    i_w1_1 = s[3]; i_w1_2 = s[4];  i_w1_3 = s[5];
    i_b1_1 = s[6]; i_b1_2 = s[7];  i_b1_3 = s[8];
    i_w2_1 = s[9]; i_w2_2 = s[10]; i_w2_3 = s[11];
    @(posedge clk);
    if (rst) begin
      for (int j = cyc; j < cyc + LAT; j++) exp_out[j] = 32'd0;
    end else begin
      exp_out[cyc + LAT] = y;
    end
    #1;
    check_eq(phase, o_final_result, exp_out[cyc]);
    cyc++;
  endtask

  localparam logic [31:0] Y_A    = 32'h4351_8000;
  localparam logic [31:0] Y_B    = 32'h4210_0000;
  localparam logic [31:0] Y_RELU = 32'h4000_0000;
  localparam logic [31:0] Y_NAN  = 32'h7FC0_0000;
  localparam logic [31:0] Y_SUB  = 32'h41A0_0000;

  set_t set_a, set_b, set_relu, set_nan, set_sub, set_r;
  real  ra[3], rw1[3], rb[3], rw2[3];

  initial begin
    for (int j = 0; j < MAXC; j++) exp_out[j] = 32'd0;
    set_a    = mkset(32'h3F800000, 32'h3F000000, 32'h40800000, 32'h40000000, 32'h40000000,
                     32'h40A00000, 32'h40400000, 32'h3FC00000, 32'h40C00000, 32'h40800000,
                     32'h40400000, 32'h40E00000);
    set_b    = mkset(32'h3F000000, 32'h3F800000, 32'h3F000000, 32'h40000000, 32'h40400000,
                     32'h40400000, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000,
                     32'h40800000, 32'h40800000);
    set_relu = mkset(32'hBF800000, 32'h3F800000, 32'h0, 32'h40000000, 32'h3F800000, 32'h0,
                     32'h3F800000, 32'h3F800000, 32'h0, 32'h40800000, 32'h3F800000, 32'h0);
    set_nan  = set_a;
    set_nan[0] = 32'h7F800000;
    set_nan[3] = 32'h0;
    set_sub  = mkset(32'h3F800000, 32'h0, 32'h0, 32'h40000000, 32'h0, 32'h0,
                     32'h40400000, 32'h00000001, 32'h0, 32'h40800000, 32'h40400000, 32'h0);

    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, set_a, 32'd0);
    phase = "hold_a";
    for (int i = 0; i < 30; i++) step(1'b0, set_a, Y_A);
    phase = "hold_b";
    for (int i = 0; i < 30; i++) step(1'b0, set_b, Y_B);
    phase = "relu";
    for (int i = 0; i < 26; i++) step(1'b0, set_relu, Y_RELU);
    phase = "b2b_aba";
    step(1'b0, set_a, Y_A);
    step(1'b0, set_b, Y_B);
    step(1'b0, set_a, Y_A);
    for (int i = 0; i < 26; i++) step(1'b0, set_relu, Y_RELU);
    phase = "mid_reset";
    for (int i = 0; i < 10; i++) step(1'b0, set_a, Y_A);
    step(1'b1, set_a, 32'd0);
    for (int i = 0; i < 27; i++) step(1'b0, set_b, Y_B);
    phase = "inf_times_zero";
    for (int i = 0; i < 26; i++) step(1'b0, set_nan, Y_NAN);
    phase = "subnormal_bias";
    for (int i = 0; i < 26; i++) step(1'b0, set_sub, Y_SUB);

    // Quarter-step values in [-16,16] keep every intermediate exact in binary32
    phase = "random";
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 3; k++) begin
        ra[k]  = real'(int'($urandom_range(0, 128)) - 64) / 4.0;
        rw1[k] = real'(int'($urandom_range(0, 128)) - 64) / 4.0;
        rb[k]  = real'(int'($urandom_range(0, 128)) - 64) / 4.0;
        rw2[k] = real'(int'($urandom_range(0, 128)) - 64) / 4.0;
        set_r[k]     = r2f(ra[k]);
        set_r[k + 3] = r2f(rw1[k]);
        set_r[k + 6] = r2f(rb[k]);
        set_r[k + 9] = r2f(rw2[k]);
      end
      step($urandom_range(0, 99) == 0, set_r, model(ra, rw1, rb, rw2));
    end
    phase = "drain";
    for (int i = 0; i < 26; i++) step(1'b0, '0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
